// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel decoder with word-alignment search.
// Decodes one 10-bit TMDS symbol per pixel clock into either a 2-bit control
// value (token) or an 8-bit data byte, and steers the upstream deserializer
// with bit-slip requests until control tokens arrive consistently.
//
// Ports:
//   clk       pixel clock, one symbol per rising edge
//   rst_n     asynchronous active-low reset
//   sym_in    10-bit TMDS symbol, bit 0 first on the wire
//   data_out  decoded data byte
//   ctrl_out  decoded control value (last token seen)
//   de_out    data_out valid (active video while locked)
//   locked    word alignment achieved
//   bitslip   one-cycle request to shift the deserializer boundary by one bit
//   slip_cnt  slips issued since reset, counts 0..9 then wraps
module tmds_channel_decoder #(
   parameter int unsigned LOCK_TOKENS    = 8,
   parameter int unsigned SEARCH_TIMEOUT = 2048,
   parameter int unsigned SLIP_WAIT      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] sym_in,
   output logic [7:0] data_out,
   output logic [1:0] ctrl_out,
   output logic       de_out,
   output logic       locked,
   output logic       bitslip,
   output logic [3:0] slip_cnt
);

   localparam int unsigned TOK_W  = $clog2(LOCK_TOKENS + 1);
   localparam int unsigned GAP_W  = $clog2(SEARCH_TIMEOUT + 1);
   localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [TOK_W-1:0]    tok_cnt, tok_nx;
   logic [GAP_W-1:0]    gap_cnt, gap_nx;
   logic [WAIT_W-1:0]   wait_cnt, wait_nx;
   logic [3:0]          slip_nx;
   logic                bitslip_nx;
   logic [7:0]          data_nx;
   logic [1:0]          ctrl_nx;
   logic                de_nx;
   logic                locked_nx;

   logic                is_tok_c;
   logic [1:0]          tok_val_c;
   logic [7:0]          d_c;
   logic [7:0]          q_c;

   // Symbol decode: control token match, otherwise undo the inversion and XOR/XNOR chain
   always_comb begin
      is_tok_c  = 1'b1;
      tok_val_c = 2'd0;
      case (sym_in)
         10'b1101010100: tok_val_c = 2'd0;
         10'b0010101011: tok_val_c = 2'd1;
         10'b0101010100: tok_val_c = 2'd2;
         10'b1010101011: tok_val_c = 2'd3;
         default:        is_tok_c  = 1'b0;
      endcase

      d_c    = sym_in[9] ? ~sym_in[7:0] : sym_in[7:0];
      q_c    = 8'd0;
      q_c[0] = d_c[0];
      for (int i = 1; i < 8; i++) begin
         q_c[i] = sym_in[8] ? (d_c[i] ^ d_c[i-1]) : ~(d_c[i] ^ d_c[i-1]);
      end
   end

   // Alignment FSM next state, counters and output register next values
   always_comb begin
      state_nx   = state;
      tok_nx     = tok_cnt;
      gap_nx     = gap_cnt;
      wait_nx    = wait_cnt;
      slip_nx    = slip_cnt;
      bitslip_nx = 1'b0;

      case (state)
         ST_SEARCH: begin
            if (is_tok_c) begin
               gap_nx = '0;
               if (tok_cnt == TOK_W'(LOCK_TOKENS - 1)) begin
                  state_nx = ST_LOCKED;
                  tok_nx   = '0;
               end else begin
                  tok_nx = tok_cnt + TOK_W'(1);
               end
            end else begin
               tok_nx = '0;
               if (gap_cnt == GAP_W'(SEARCH_TIMEOUT - 1)) begin
                  state_nx   = ST_SLIP_WAIT;
                  gap_nx     = '0;
                  wait_nx    = '0;
                  bitslip_nx = 1'b1;
                  slip_nx    = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
               end else begin
                  gap_nx = gap_cnt + GAP_W'(1);
               end
            end
         end

         // Symbols are ignored while the deserializer settles on its new boundary
         ST_SLIP_WAIT: begin
            if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
               state_nx = ST_SEARCH;
               wait_nx  = '0;
               tok_nx   = '0;
               gap_nx   = '0;
            end else begin
               wait_nx = wait_cnt + WAIT_W'(1);
            end
         end

         ST_LOCKED: begin
            if (is_tok_c) begin
               gap_nx = '0;
               if (tok_cnt != TOK_W'(LOCK_TOKENS)) begin
                  tok_nx = tok_cnt + TOK_W'(1);
               end
            end else begin
               tok_nx = '0;
               if (gap_cnt == GAP_W'(SEARCH_TIMEOUT - 1)) begin
                  state_nx = ST_SEARCH;
                  gap_nx   = '0;
               end else begin
                  gap_nx = gap_cnt + GAP_W'(1);
               end
            end
         end

         default: begin
            state_nx = ST_SEARCH;
            tok_nx   = '0;
            gap_nx   = '0;
            wait_nx  = '0;
         end
      endcase

      // de_out qualifies with the lock state that will be visible alongside the byte
      locked_nx = (state_nx == ST_LOCKED);
      if (is_tok_c) begin
         data_nx = 8'd0;
         ctrl_nx = tok_val_c;
         de_nx   = 1'b0;
      end else begin
         data_nx = q_c;
         ctrl_nx = ctrl_out;
         de_nx   = locked_nx;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_SEARCH;
         tok_cnt  <= '0;
         gap_cnt  <= '0;
         wait_cnt <= '0;
         slip_cnt <= 4'd0;
         bitslip  <= 1'b0;
         data_out <= 8'd0;
         ctrl_out <= 2'd0;
         de_out   <= 1'b0;
         locked   <= 1'b0;
      end else begin
         state    <= state_nx;
         tok_cnt  <= tok_nx;
         gap_cnt  <= gap_nx;
         wait_cnt <= wait_nx;
         slip_cnt <= slip_nx;
         bitslip  <= bitslip_nx;
         data_out <= data_nx;
         ctrl_out <= ctrl_nx;
         de_out   <= de_nx;
         locked   <= locked_nx;
      end
   end

endmodule
